// File: rtl/osc_pkg.sv
// -----------------------------------------------------------------------------
// osc_pkg
// Shared types and constants for the oscilloscope capture engine.
//   osc_cap_state_t : capture FSM state encoding
//   TRIG_RISING     : trig_edge value selecting a rising-edge trigger
//   TRIG_FALLING    : trig_edge value selecting a falling-edge trigger
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package osc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        WAIT_TRIG = 3'd2,
        POST_FILL = 3'd3,
        DONE      = 3'd4
    } osc_cap_state_t;

    localparam logic TRIG_RISING  = 1'b0;
    localparam logic TRIG_FALLING = 1'b1;

endpackage : osc_pkg

// File: rtl/osc_cap_ram.sv
// -----------------------------------------------------------------------------
// osc_cap_ram
// Simple dual-port sample buffer: one write port, one registered read port.
// A read that collides with a write to the same address returns the old data.
//   ad_clk  : clock
//   rst_n   : asynchronous active-low reset (read register only)
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : mem[rd_addr], one cycle after rd_addr
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module osc_cap_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              ad_clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto block RAM; only the
    // output register is reset. Non-blocking assignments on both ports give the
    // read-old-data behaviour on a same-address collision.
    always_ff @(posedge ad_clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : osc_cap_ram

// File: rtl/osc_capture.sv
// -----------------------------------------------------------------------------
// osc_capture
// Oscilloscope capture engine. Decimated samples are written into a circular
// buffer; after pre_depth pre-trigger samples the engine looks for an edge
// crossing of trig_level (or force_trig), then fills the post-trigger part of
// the buffer and freezes it for the waveform renderer.
//   ad_clk     : ADC/sample clock
//   rst_n      : asynchronous active-low reset
//   ad_data    : ADC sample, valid with deci_valid
//   deci_valid : one-cycle decimated-sample strobe
//   arm        : one-cycle pulse, starts/restarts a capture (highest priority)
//   force_trig : level, triggers on the next accepted sample in WAIT_TRIG
//   trig_level : unsigned trigger threshold
//   trig_edge  : 0 = rising, 1 = falling
//   pre_depth  : pre-trigger sample count, latched at arm
//   busy       : capture in progress
//   cap_done   : waveform frozen, held until the next arm
//   trig_addr  : buffer address of the trigger sample
//   wave_start : buffer address of the oldest waveform sample
//   rd_addr    : read address
//   rd_data    : buffer data, one cycle after rd_addr
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module osc_capture
    import osc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              ad_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              deci_valid,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] pre_depth,
    output logic              busy,
    output logic              cap_done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] wave_start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    osc_cap_state_t state, state_next;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_inc;
    logic [ADDR_W-1:0] pre_lat;
    logic [ADDR_W-1:0] post_len;
    logic [DATA_W-1:0] prev;
    logic              prev_ok;

    logic capturing;
    logic accept;
    logic rise_hit;
    logic fall_hit;
    logic trig_hit;

    // ------------------------------------------------------------------
    // Shared combinational terms
    // ------------------------------------------------------------------
    assign capturing = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST_FILL);

    // A sample arriving together with arm is discarded.
    assign accept  = deci_valid && capturing && !arm;
    assign cnt_inc = cnt + ADDR_W'(1);

    // DEPTH-1 is all ones, so DEPTH-1-pre_lat is just the bitwise inverse.
    assign post_len = ~pre_lat;

    // Edge comparator against the previous accepted sample. prev_ok blocks a
    // false crossing on the first sample after arm.
    assign rise_hit = prev_ok && (prev < trig_level) && (ad_data >= trig_level);
    assign fall_hit = prev_ok && (prev > trig_level) && (ad_data <= trig_level);
    assign trig_hit = ((trig_edge == TRIG_RISING) ? rise_hit : fall_hit) || force_trig;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_next gets a default before any branch so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_next = state;
        if (arm) begin
            // pre_depth is ADDR_W bits wide, so it can never exceed DEPTH-1;
            // the clamp to DEPTH-1 is implicit in the port width.
            state_next = (pre_depth == '0) ? WAIT_TRIG : PRE_FILL;
        end else if (accept) begin
            unique case (state)
                PRE_FILL: begin
                    if (cnt_inc == pre_lat) begin
                        state_next = WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (trig_hit) begin
                        state_next = (post_len == '0) ? DONE : POST_FILL;
                    end
                end
                POST_FILL: begin
                    if (cnt_inc == post_len) begin
                        state_next = DONE;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        busy     = capturing;
        cap_done = (state == DONE);
    end

    // ------------------------------------------------------------------
    // Datapath: write pointer, counters, previous sample, trigger address
    // ------------------------------------------------------------------
    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            cnt        <= '0;
            pre_lat    <= '0;
            prev       <= '0;
            prev_ok    <= 1'b0;
            trig_addr  <= '0;
            wave_start <= '0;
        end else if (arm) begin
            wr_ptr  <= '0;
            cnt     <= '0;
            prev_ok <= 1'b0;
            pre_lat <= pre_depth;
        end else if (accept) begin
            wr_ptr  <= wr_ptr + ADDR_W'(1);
            prev    <= ad_data;
            prev_ok <= 1'b1;
            unique case (state)
                PRE_FILL: begin
                    cnt <= cnt_inc;
                end
                WAIT_TRIG: begin
                    if (trig_hit) begin
                        // wr_ptr still points at the sample being written.
                        trig_addr  <= wr_ptr;
                        wave_start <= wr_ptr - pre_lat;
                        cnt        <= '0;
                    end
                end
                POST_FILL: begin
                    cnt <= cnt_inc;
                end
                default: cnt <= cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer
    // ------------------------------------------------------------------
    osc_cap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .ad_clk  (ad_clk),
        .rst_n   (rst_n),
        .we      (accept),
        .wr_addr (wr_ptr),
        .wr_data (ad_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule : osc_capture

// File: tb/tb_osc_capture.sv
`timescale 1ns/1ps

module tb_osc_capture;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              ad_clk = 1'b0;
    logic              rst_n  = 1'b0;
    logic [DATA_W-1:0] ad_data;
    logic              deci_valid;
    logic              arm;
    logic              force_trig;
    logic [DATA_W-1:0] trig_level;
    logic              trig_edge;
    logic [ADDR_W-1:0] pre_depth;
    logic              busy;
    logic              cap_done;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] wave_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    osc_capture #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .ad_clk     (ad_clk),
        .rst_n      (rst_n),
        .ad_data    (ad_data),
        .deci_valid (deci_valid),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .pre_depth  (pre_depth),
        .busy       (busy),
        .cap_done   (cap_done),
        .trig_addr  (trig_addr),
        .wave_start (wave_start),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 ad_clk = ~ad_clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One capture scenario: ramp data start + step*k, one sample every gap+1 cycles.
    typedef struct {
        string name;
        int    pre;
        bit    falling;
        int    level;
        bit    frc;
        int    start;
        int    step;
        int    gap;
        int    exp_n;       // accepted samples from arm until cap_done
        int    exp_trig;
        int    exp_ws;
        int    exp_tval;    // ram[trig_addr]
        int    exp_pval;    // ram[trig_addr-1]
        int    exp_first;   // ram[wave_start]; the waveform then advances by step
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge ad_clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input int gap);
        ad_data    = d;
        deci_valid = 1'b1;
        tick();
        deci_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_arm(input logic [ADDR_W-1:0] pre);
        pre_depth = pre;
        arm       = 1'b1;
        tick();
        arm       = 1'b0;
    endtask

    // Feeds ramp samples until cap_done or the sample limit; returns the count.
    task automatic run_to_done(input int start, input int step, input int gap,
                               input int limit, output int n);
        n = 0;
        while (!cap_done && n < limit) begin
            send(8'(start + step * n), gap);
            n++;
        end
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    // Reads the whole waveform from wave_start and counts out-of-sequence samples.
    task automatic scan(input string name, input logic [ADDR_W-1:0] ws,
                        input int first, input int step);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ws + ADDR_W'(i);
            tick();
            if (rd_data !== 8'(first + step * i)) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        int                n;
        logic [DATA_W-1:0] d;

        //         name          pre   fall lvl  frc start step gap  n     trig ws   tval pval first
        vecs[0] = '{"rise_100",   100,  0,  128, 0,  28,   1,  3, 1024,  100, 0,   128, 127, 28};
        vecs[1] = '{"fall_wrap",  1000, 1,  50,  0,  56,  -1,  1, 1054,  6,   30,  50,  51,  26};
        vecs[2] = '{"pre_0",      0,    0,  128, 1,  10,   1,  1, 1024,  0,   0,   10,  9,   10};
        vecs[3] = '{"pre_1023",   1023, 0,  128, 0,  0,    1,  3, 1153,  128, 129, 128, 127, 129};
        vecs[4] = '{"pre_1023_r1",1023, 0,  128, 0,  0,    1,  0, 1153,  128, 129, 128, 127, 129};

        ad_data    = '0;
        deci_valid = 1'b0;
        arm        = 1'b0;
        force_trig = 1'b0;
        trig_level = 8'd128;
        trig_edge  = 1'b0;
        pre_depth  = '0;
        rd_addr    = '0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_cap_done", cap_done, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_wave_start", wave_start, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of POST_FILL, then a clean restart
        force_trig = 1'b1;
        do_arm(10'd4);
        for (int k = 0; k < 10; k++) send(8'(k), 0);
        check("midpost_busy", busy, 1);
        check("midpost_trig_addr", trig_addr, 4);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", busy, 0);
        check("midrst_cap_done", cap_done, 0);
        check("midrst_trig_addr", trig_addr, 0);
        check("midrst_wave_start", wave_start, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_arm(10'd4);
        run_to_done(0, 1, 0, 2000, n);
        force_trig = 1'b0;
        check("rearm_n", n, 1024);
        check("rearm_cap_done", cap_done, 1);
        check("rearm_trig_addr", trig_addr, 4);
        check("rearm_wave_start", wave_start, 0);

        // Table-driven captures
        for (int v = 0; v < 5; v++) begin
            trig_edge  = vecs[v].falling;
            trig_level = 8'(vecs[v].level);
            force_trig = vecs[v].frc;
            do_arm(ADDR_W'(vecs[v].pre));
            check({vecs[v].name, "_busy_armed"}, busy, 1);
            check({vecs[v].name, "_done_armed"}, cap_done, 0);
            run_to_done(vecs[v].start, vecs[v].step, vecs[v].gap, 3000, n);
            force_trig = 1'b0;
            check({vecs[v].name, "_n"}, n, vecs[v].exp_n);
            check({vecs[v].name, "_cap_done"}, cap_done, 1);
            check({vecs[v].name, "_busy"}, busy, 0);
            check({vecs[v].name, "_trig_addr"}, trig_addr, vecs[v].exp_trig);
            check({vecs[v].name, "_wave_start"}, wave_start, vecs[v].exp_ws);
            rd(ADDR_W'(vecs[v].exp_trig), d);
            check({vecs[v].name, "_ram_trig"}, d, vecs[v].exp_tval);
            rd(ADDR_W'(vecs[v].exp_trig - 1), d);
            check({vecs[v].name, "_ram_prev"}, d, vecs[v].exp_pval);
            scan({vecs[v].name, "_contig"}, ADDR_W'(vecs[v].exp_ws),
                 vecs[v].exp_first, vecs[v].step);
        end

        // arm in WAIT_TRIG together with a sample: the sample is dropped, wr_ptr restarts
        trig_edge  = 1'b0;
        trig_level = 8'd128;
        do_arm(10'd2);
        for (int k = 0; k < 5; k++) send(8'(k), 0);
        ad_data    = 8'd99;
        deci_valid = 1'b1;
        pre_depth  = 10'd2;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
        deci_valid = 1'b0;
        check("prio_busy", busy, 1);
        check("prio_cap_done", cap_done, 0);
        force_trig = 1'b1;
        run_to_done(10, 1, 0, 2000, n);
        force_trig = 1'b0;
        check("prio_trig_addr", trig_addr, 2);
        check("prio_n", n, 1024);
        rd(10'd0, d);
        check("prio_ram0", d, 10);

        // Read latency: new address shows its data exactly one edge later
        rd_addr = 10'd5;
        tick();
        check("rd_lat_a", rd_data, 15);
        rd_addr = 10'd6;
        #1;
        check("rd_lat_hold", rd_data, 15);
        tick();
        check("rd_lat_b", rd_data, 16);

        // Crossing on the very first sample after arm must not trigger
        // (last accepted sample before this arm was 9, below the level)
        do_arm(10'd0);
        send(8'd200, 0);
        check("first_no_trig", trig_addr, 2);
        check("first_busy", busy, 1);
        send(8'd201, 0);
        send(8'd100, 0);
        send(8'd150, 0);
        check("second_trig_addr", trig_addr, 3);
        run_to_done(150, 0, 0, 2000, n);
        check("second_post_n", n, 1023);
        check("second_cap_done", cap_done, 1);

        // Force trigger on constant data
        do_arm(10'd3);
        for (int k = 0; k < 8; k++) send(8'd200, 1);
        check("force_wait_busy", busy, 1);
        check("force_wait_trig_addr", trig_addr, 3);
        force_trig = 1'b1;
        send(8'd200, 0);
        force_trig = 1'b0;
        check("force_trig_addr", trig_addr, 8);
        check("force_wave_start", wave_start, 5);
        run_to_done(200, 0, 1, 2000, n);
        check("force_post_n", n, 1020);
        check("force_cap_done", cap_done, 1);
        rd(10'd8, d);
        check("force_ram", d, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_osc_capture
